// File: rtl/simon_core_param.sv
// simon_core_param: iterative SIMON block cipher, one round per cycle, key schedule computed on the fly.
// Define SIMON_DECRYPT_EN to add a T-entry round-key buffer, an EXPAND pass and decryption (mode_i=1).
module simon_core_param #(
    parameter int WORD_W    = 64,
    parameter int KEY_WORDS = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start_i,
    output logic                    ready_o,
    input  logic                    mode_i,
    input  logic [2*WORD_W-1:0]     pt_i,
    input  logic [WORD_W*KEY_WORDS-1:0] k0_i,
    output logic                    valid_o,
    input  logic                    out_ready_i,
    output logic [2*WORD_W-1:0]     ct_o
);
    localparam int W = WORD_W;
    localparam int M = KEY_WORDS;
    localparam bit LEGAL = (W == 32 && (M == 3 || M == 4)) || (W == 64 && M >= 2 && M <= 4);
    localparam int T = (W == 32) ? ((M == 3) ? 42 : 44) : ((M == 2) ? 68 : (M == 3) ? 69 : 72);
    localparam int CW = $clog2(T);
    // z sequences written z[0] first, so z[i] lives at bit 61-i
    localparam logic [61:0] Z2 = 62'b10101111011100000011010010011000101000010001111110010110110011;
    localparam logic [61:0] Z3 = 62'b11011011101011000110010111100000010010001010011100110100001111;
    localparam logic [61:0] Z4 = 62'b11010001111001101011011000100000010111000011001010010011101111;
    localparam logic [61:0] Z = ((W == 32 && M == 3) || (W == 64 && M == 2)) ? Z2 :
                                ((W == 32 && M == 4) || (W == 64 && M == 3)) ? Z3 : Z4;

    if (!LEGAL) begin : g_illegal
        $error("simon_core_param: unsupported WORD_W/KEY_WORDS pair");
    end

    function automatic logic [W-1:0] rol(input logic [W-1:0] v, input int j);
        return (v << j) | (v >> (W - j));
    endfunction

    function automatic logic [W-1:0] f(input logic [W-1:0] v);
        return (rol(v, 1) & rol(v, 8)) ^ rol(v, 2);
    endfunction

`ifdef SIMON_DECRYPT_EN
    typedef enum logic [1:0] {IDLE, EXPAND, ROUND, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;
`endif

    state_t            state_q;
    logic [W-1:0]      x_q, y_q;
    logic [W-1:0]      kw_q [M];
    logic [CW-1:0]     cnt_q;
    logic [2*W-1:0]    ct_q;
    logic              valid_q, ready_q;
    logic [W-1:0]      tmp, key_d, rk, x_d, y_d;
    logic [5:0]        zi;
    logic              last, dec;

`ifdef SIMON_DECRYPT_EN
    logic              mode_q;
    logic [W-1:0]      rk_q [T];
    assign dec = mode_q;
`else
    logic              unused_mode;
    assign unused_mode = mode_i;
    assign dec = 1'b0;
`endif

    always_comb begin
        zi    = (int'(cnt_q) >= 62) ? 6'(int'(cnt_q) - 62) : 6'(cnt_q);
        tmp   = rol(kw_q[M-1], W - 3) ^ ((M == 4) ? kw_q[1] : '0);
        key_d = ~W'(3) ^ W'(Z[6'd61 - zi]) ^ kw_q[0] ^ tmp ^ rol(tmp, W - 1);
`ifdef SIMON_DECRYPT_EN
        rk    = dec ? rk_q[CW'(T - 1) - cnt_q] : kw_q[0];
`else
        rk    = kw_q[0];
`endif
        x_d   = dec ? y_q : y_q ^ f(x_q) ^ rk;
        y_d   = dec ? x_q ^ f(y_q) ^ rk : x_q;
        last  = cnt_q == CW'(T - 1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            ct_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            cnt_q   <= '0;
            for (int j = 0; j < M; j++) kw_q[j] <= '0;
`ifdef SIMON_DECRYPT_EN
            mode_q  <= 1'b0;
            for (int j = 0; j < T; j++) rk_q[j] <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: if (start_i) begin
                    x_q     <= pt_i[2*W-1:W];
                    y_q     <= pt_i[W-1:0];
                    for (int j = 0; j < M; j++) kw_q[j] <= k0_i[j*W +: W];
                    cnt_q   <= '0;
                    ready_q <= 1'b0;
`ifdef SIMON_DECRYPT_EN
                    mode_q  <= mode_i;
                    state_q <= mode_i ? EXPAND : ROUND;
`else
                    state_q <= ROUND;
`endif
                end
`ifdef SIMON_DECRYPT_EN
                EXPAND: begin
                    rk_q[cnt_q] <= kw_q[0];
                    for (int j = 0; j < M - 1; j++) kw_q[j] <= kw_q[j+1];
                    kw_q[M-1] <= key_d;
                    cnt_q     <= last ? '0 : cnt_q + CW'(1);
                    if (last) state_q <= ROUND;
                end
`endif
                ROUND: begin
                    x_q <= x_d;
                    y_q <= y_d;
                    for (int j = 0; j < M - 1; j++) kw_q[j] <= kw_q[j+1];
                    kw_q[M-1] <= key_d;
`ifdef SIMON_DECRYPT_EN
                    if (!mode_q) rk_q[cnt_q] <= kw_q[0];
`endif
                    cnt_q <= last ? '0 : cnt_q + CW'(1);
                    if (last) begin
                        ct_q    <= {x_d, y_d};
                        valid_q <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: if (out_ready_i) begin
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ready_o = ready_q;
    assign valid_o = valid_q;
    assign ct_o    = ct_q;
endmodule
